// File: rtl/rfile_sync.sv
// Synchronous-read register file: 2 read ports, 1 byte-enabled write port,
// optional zero register, sweep-cleared array. RFILE_BYPASS_EN selects write-first collision reads.
module rfile_sync #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                regWrite,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   writeR,
  input  logic [DATA_W-1:0]   writeRData,
  input  logic [ADDR_W-1:0]   inR1,
  input  logic [ADDR_W-1:0]   inR2,
  output logic [DATA_W-1:0]   Rdata1,
  output logic [DATA_W-1:0]   Rdata2,
  output logic                ready
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] main [DEPTH];

  logic              zero_wr;
  logic              we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  always_comb begin
    zero_wr = (ZERO_REG != 0) && (writeR == '0);
    we      = (state == READY) && regWrite && !clr && !zero_wr;
  end

  // Single array write port shared by the clear sweep and user writes.
  always_comb begin
    if (state == CLEAR) begin
      mem_we   = !rst;
      mem_addr = clr_idx;
      mem_data = '0;
      mem_be   = '1;
    end else begin
      mem_we   = we && !rst;
      mem_addr = writeR;
      mem_data = writeRData;
      mem_be   = wbe;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (mem_be[k]) main[mem_addr][8*k +: 8] <= mem_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd1_next = main[inR1];
    rd2_next = main[inR2];
`ifdef RFILE_BYPASS_EN
    for (int unsigned k = 0; k < NB; k++) begin
      if (we && wbe[k]) begin
        if (inR1 == writeR) rd1_next[8*k +: 8] = writeRData[8*k +: 8];
        if (inR2 == writeR) rd2_next[8*k +: 8] = writeRData[8*k +: 8];
      end
    end
`endif
    if ((ZERO_REG != 0) && (inR1 == '0)) rd1_next = '0;
    if ((ZERO_REG != 0) && (inR2 == '0)) rd2_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
      Rdata1  <= '0;
      Rdata2  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          Rdata1  <= '0;
          Rdata2  <= '0;
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          Rdata1 <= rd1_next;
          Rdata2 <= rd2_next;
          if (clr) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rfile_sync.sv
// Self-checking bench for rfile_sync: ZERO_REG=1 and ZERO_REG=0 instances
// share stimulus and are checked against a word-array reference model.
module tb_rfile_sync;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst, clr, regWrite;
  logic [3:0]    wbe;
  logic [AW-1:0] writeR, inR1, inR2;
  logic [DW-1:0] writeRData;
  logic [DW-1:0] z_r1, z_r2, n_r1, n_r2;
  logic          z_rdy, n_rdy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] ma [DEPTH];  // ZERO_REG=1 instance
  logic [DW-1:0] mb [DEPTH];  // ZERO_REG=0 instance
  int            sweep_left;
  logic [DW-1:0] e_z1, e_z2, e_n1, e_n2;
  logic          e_rdy;

  always #5 clk = ~clk;

  rfile_sync #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .clr(clr), .regWrite(regWrite), .wbe(wbe),
    .writeR(writeR), .writeRData(writeRData), .inR1(inR1), .inR2(inR2),
    .Rdata1(z_r1), .Rdata2(z_r2), .ready(z_rdy));

  rfile_sync #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_n (
    .clk(clk), .rst(rst), .clr(clr), .regWrite(regWrite), .wbe(wbe),
    .writeR(writeR), .writeRData(writeRData), .inR1(inR1), .inR2(inR2),
    .Rdata1(n_r1), .Rdata2(n_r2), .ready(n_rdy));

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old);
    logic [DW-1:0] w = old;
    for (int k = 0; k < 4; k++)
      if (wbe[k]) w[8*k +: 8] = writeRData[8*k +: 8];
    return w;
  endfunction

  function automatic logic [DW-1:0] model_read(input bit zr, input logic [AW-1:0] a, input bit wr);
    logic [DW-1:0] w;
    if (zr && a == 0) return '0;
    w = zr ? ma[a] : mb[a];
`ifdef RFILE_BYPASS_EN
    if (wr && a == writeR) w = merge(w);
`else
    if (wr && a == writeR) w = w;
`endif
    return w;
  endfunction

  function automatic logic [4*DW+1:0] dut_vec();
    return {z_rdy, n_rdy, z_r1, z_r2, n_r1, n_r2};
  endfunction

  function automatic logic [4*DW+1:0] exp_vec();
    return {e_rdy, e_rdy, e_z1, e_z2, e_n1, e_n2};
  endfunction

  // One clock: predict from pre-edge inputs, then advance and commit.
  task automatic step();
    bit wr_a, wr_b, restart;
    logic [DW-1:0] na, nb;
    restart = 0;
    wr_a = 0; wr_b = 0;
    if (rst) begin
      restart = 1;
      e_z1 = '0; e_z2 = '0; e_n1 = '0; e_n2 = '0;
    end else if (sweep_left > 0) begin
      e_z1 = '0; e_z2 = '0; e_n1 = '0; e_n2 = '0;
      sweep_left--;
      if (sweep_left == 0) e_rdy = 1'b1;
    end else begin
      wr_b = regWrite && !clr;
      wr_a = wr_b && (writeR != 0);
      e_z1 = model_read(1, inR1, wr_a);
      e_z2 = model_read(1, inR2, wr_a);
      e_n1 = model_read(0, inR1, wr_b);
      e_n2 = model_read(0, inR2, wr_b);
      if (clr) restart = 1;
    end
    na = merge(ma[writeR]);
    nb = merge(mb[writeR]);
    @(posedge clk);
    #1;
    if (restart) begin
      sweep_left = DEPTH;
      e_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin ma[i] = '0; mb[i] = '0; end
    end else begin
      if (wr_a) ma[writeR] = na;
      if (wr_b) mb[writeR] = nb;
    end
  endtask

  task automatic idle_inputs();
    rst = 0; clr = 0; regWrite = 0; wbe = 4'h0;
    writeR = '0; writeRData = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    regWrite = 1; writeR = a; writeRData = d; wbe = be;
    step();
    regWrite = 0; wbe = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    inR1 = '0; inR2 = '0;
    rst = 1;
    step(); step();
    checks++;
    if (dut_vec() !== exp_vec() || z_rdy !== 1'b0 || z_r1 !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
    end
    rst = 0;
    inR1 = 5'd3; inR2 = 5'd17;
    for (int c = 1; c <= DEPTH; c++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec() || z_rdy !== (c == DEPTH)) begin
        failures++;
        $display("FAIL sweep_cycle%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      inR1 = AW'(i); inR2 = AW'(DEPTH - 1 - i);
      step();
      checks++;
      if (dut_vec() !== exp_vec() || n_r1 !== '0 || n_r2 !== '0) begin
        failures++;
        $display("FAIL readback_zero addr%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    do_write(5'd5, 32'hDEADBEEF, 4'hF);
    inR1 = 5'd5; inR2 = 5'd6;
    step();
    checks++;
    if (z_r1 !== 32'hDEADBEEF || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL basic_rw got=%h exp=%h", z_r1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_en();
    do_write(5'd7, 32'h11223344, 4'hF);
    do_write(5'd7, 32'hAABBCCDD, 4'b0101);
    do_write(5'd7, 32'h55555555, 4'h0);
    inR1 = 5'd7; inR2 = 5'd7;
    step();
    checks++;
    if (z_r1 !== 32'h11BB33DD || z_r2 !== 32'h11BB33DD || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL byte_en got=%h/%h exp=%h", z_r1, z_r2, 32'h11BB33DD);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFFFFFF, 4'hF);
    inR1 = 5'd0; inR2 = 5'd0;
    step();
    checks++;
    if (z_r1 !== '0 || z_r2 !== '0 || n_r1 !== 32'hFFFFFFFF || n_r2 !== 32'hFFFFFFFF
        || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL zero_reg got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
`ifdef RFILE_BYPASS_EN
    want = 32'h2;
`else
    want = 32'h1;
`endif
    do_write(5'd3, 32'h1, 4'hF);
    inR1 = 5'd4; inR2 = 5'd3;
    do_write(5'd3, 32'h2, 4'hF);
    checks++;
    if (z_r2 !== want || n_r2 !== want || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL collision got=%h exp=%h", z_r2, want);
    end
    step();
    checks++;
    if (z_r2 !== 32'h2 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL collision_next got=%h exp=%h", z_r2, 32'h2);
    end
  endtask

  task automatic test_clr();
    int n;
    do_write(5'd9, 32'hCAFEF00D, 4'hF);
    clr = 1; regWrite = 1; writeR = 5'd9; writeRData = 32'h12345678; wbe = 4'hF;
    inR1 = 5'd9; inR2 = 5'd9;
    step();
    clr = 0; regWrite = 0; wbe = 4'h0;
    n = 0;
    while (z_rdy !== 1'b1 && n < 40) begin
      regWrite = 1; writeR = 5'd9; wbe = 4'hF; writeRData = $urandom;
      step();
      n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL clr_sweep c%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      end
    end
    regWrite = 0; wbe = 4'h0;
    checks++;
    if (n !== DEPTH) begin
      failures++;
      $display("FAIL clr_ready_latency got=%0d exp=%0d", n, DEPTH);
    end
    step();
    checks++;
    if (z_r1 !== '0 || n_r2 !== '0 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL clr_entry9 got=%h exp=0", z_r1);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    clr = 1;
    step();
    clr = 0;
    for (int c = 0; c < 10; c++) step();
    rst = 1;
    step();
    rst = 0;
    n = 0;
    while (z_rdy !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== DEPTH || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL rst_mid_sweep latency got=%0d exp=%0d", n, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      regWrite   = ($urandom_range(0, 2) != 0);
      wbe        = 4'($urandom);
      writeR     = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      writeRData = $urandom;
      inR1       = ($urandom_range(0, 2) == 0) ? writeR : AW'($urandom_range(0, 7));
      inR2       = ($urandom_range(0, 2) == 0) ? writeR : AW'($urandom);
      clr        = ($urandom_range(0, 149) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    sweep_left = DEPTH;
    e_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin ma[i] = '0; mb[i] = '0; end
    test_reset();
    test_basic();
    test_byte_en();
    test_zero_reg();
    test_collision();
    test_clr();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfile_sync.md
Name: rfile_sync

Overview:
- Parametrised, synchronous-read register file: the next-generation register bank for the processor datapath.
- Two read ports and one write port with per-byte write enables.
- Optional hard-wired zero register.
- Contents are cleared by a built-in sweep sequencer after reset or on request, so the array can map onto block RAM instead of a flop-per-bit reset.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
clr  input  1  one-cycle request to re-clear all entries; sampled only in READY
regWrite  input  1  write strobe
wbe  input  DATA_W/8  byte enables; bit k enables byte k, bits [8k+7:8k]
writeR  input  ADDR_W  write address
writeRData  input  DATA_W  write data
inR1  input  ADDR_W  read address, port 1
inR2  input  ADDR_W  read address, port 2
Rdata1  output  DATA_W  registered read data, port 1
Rdata2  output  DATA_W  registered read data, port 2
ready  output  1  1 = array cleared and accepting writes

Behaviour:
- Two-state FSM: CLEAR and READY; clear index clr_idx is ADDR_W bits wide.
- Reset, when rst=1 at an edge:
  - state <= CLEAR, clr_idx <= 0, ready <= 0, Rdata1 <= 0, Rdata2 <= 0.
  - rst overrides clr and regWrite in the same cycle.
  - Asserting rst mid-sweep restarts the sweep from clr_idx=0.
- CLEAR state:
  - Each cycle, main[clr_idx] <= 0 and clr_idx increments.
  - When clr_idx == DEPTH-1, that entry is cleared and state <= READY on the same edge.
  - ready = 1 exactly DEPTH cycles after the last edge with rst=1 (or after the clr edge).
  - regWrite is ignored during CLEAR; writes are dropped, not queued.
  - Rdata1 and Rdata2 are registered to 0 every CLEAR cycle.
  - clr is ignored during CLEAR.
- READY state:
  - ready = 1.
  - clr=1 at an edge: state <= CLEAR and clr_idx <= 0. Any regWrite in that same cycle is dropped.
  - Write: when regWrite=1, then for each k with wbe[k]=1, byte k of main[writeR] <= byte k of writeRData. Bytes with wbe[k]=0 keep their value.
  - wbe all-zero with regWrite=1 is a no-op.
  - ZERO_REG=1 and writeR=0: the write is discarded.
- Reads, READY state only:
  - Rdata1 <= main[inR1] and Rdata2 <= main[inR2] every cycle; there is no read enable.
  - One-cycle latency: an address presented before edge N appears on Rdata after edge N.
  - inR1 == inR2 is legal; both ports return the same word.
  - ZERO_REG=1 and address 0: Rdata <= 0 regardless of array contents.
- Read/write collision: the same address is read and written in the same cycle. The result is set by the optional feature below.
- Outputs change only on clock edges; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: RFILE_BYPASS_EN.
- Defined: a read port whose address equals writeR, with regWrite=1 in READY and the write not discarded by ZERO_REG, returns merged data.
  - Bytes with wbe[k]=1 come from writeRData.
  - All other bytes come from the stored word.
  - This is write-first behaviour.
- Undefined: a colliding read returns the stored word from before the write (read-first). The new value is visible on the following read.
- In both builds, reads during CLEAR return 0 and ZERO_REG reads of entry 0 return 0.

Test Plan:
- Reset sweep, DEPTH=32: rst=1 for 2 cycles, then 0 -> ready=0 for 32 cycles then 1; all 32 addresses read back 32'h0; Rdata1 and Rdata2 are 0 throughout the sweep.
- Basic write/read: writeR=5, writeRData=32'hDEADBEEF, wbe=4'hF; next cycle inR1=5 -> Rdata1=32'hDEADBEEF one cycle after the address is applied.
- Byte enables: main[7]=32'h11223344, then write 32'hAABBCCDD with wbe=4'b0101 -> main[7] reads 32'h11BB33DD.
- Zero register, ZERO_REG=1: write 32'hFFFFFFFF to address 0 -> inR1=0 and inR2=0 both read 0. With ZERO_REG=0 the same sequence reads 32'hFFFFFFFF.
- Collision: main[3]=32'h1, then write 32'h2 to address 3 while inR2=3 -> Rdata2=32'h2 with RFILE_BYPASS_EN, 32'h1 without; the next cycle reads 32'h2 in both builds.
- clr and rst mid-operation:
  - Pulse clr in READY with regWrite=1 to address 9 -> write dropped, ready=0 for 32 cycles, main[9]=0 afterwards.
  - Assert rst at sweep cycle 10 -> ready rises 32 cycles after rst deasserts.
